// File: rtl/seg_display_driver.sv
// seg_display_driver
// Multi-digit, anode-multiplexed seven-segment driver. A captured binary value
// is converted to BCD with one shift-add-3 step per clock. The result is then
// committed atomically to the display registers, so a conversion in progress
// never disturbs the digits being shown.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN: leading zeros are blanked and
// the minus sign sits just left of the most significant nonzero digit.
// When the macro is undefined, digits are zero-padded and the minus sign goes
// in the leftmost digit.
module seg_display_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int DATA_W       = 8,
   parameter int REFRESH_BITS = 18,
   parameter int SIGNED       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     num,
   input  logic                  load,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] Anode,
   output logic [6:0]            LED_out
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (b[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = b[i*4 +: 4];
         end
      end
      return r;
   endfunction

   // Active-low segment pattern {a,b,c,d,e,f,g} for a BCD digit
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   state_t                  state_r, state_s;
   logic [DATA_W-1:0]       mag_r, mag_s;
   logic [BCD_W-1:0]        bcd_r, bcd_s, adj_s;
   logic                    neg_pend_r, neg_pend_s;
   logic [CNT_W-1:0]        step_r, step_s;
   logic                    commit_s;
   logic [BCD_W-1:0]        disp_bcd_r;
   logic [NUM_DIGITS-1:0]   blank_r, blank_s;
   logic [NUM_DIGITS-1:0]   sign_r, sign_s;
   logic [REFRESH_BITS-1:0] refresh_r;
   logic [IDX_W-1:0]        idx_r, pos_s;
   logic [3:0]              nib_s;
   logic                    dig_blank_s, dig_sign_s;
   logic [NUM_DIGITS-1:0]   anode_s;
   logic [6:0]              seg_s;

   // Conversion FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         mag_r      <= '0;
         bcd_r      <= '0;
         neg_pend_r <= 1'b0;
         step_r     <= '0;
         busy       <= 1'b0;
      end else begin
         state_r    <= state_s;
         mag_r      <= mag_s;
         bcd_r      <= bcd_s;
         neg_pend_r <= neg_pend_s;
         step_r     <= step_s;
         busy       <= (state_s != IDLE);
      end
   end

   // Next-state logic: capture on load, DATA_W shift-add-3 steps, then a one-cycle commit
   always_comb begin
      state_s    = state_r;
      mag_s      = mag_r;
      bcd_s      = bcd_r;
      neg_pend_s = neg_pend_r;
      step_s     = step_r;
      commit_s   = 1'b0;
      adj_s      = bcd_adjust(bcd_r);
      case (state_r)
         IDLE: begin
            if (load) begin
               if ((SIGNED != 0) && num[DATA_W-1]) begin
                  // Unsigned DATA_W negation maps the most negative value to its magnitude
                  mag_s      = ~num + DATA_W'(1);
                  neg_pend_s = 1'b1;
               end else begin
                  mag_s      = num;
                  neg_pend_s = 1'b0;
               end
               bcd_s   = '0;
               step_s  = '0;
               state_s = CONVERT;
            end else begin
               state_s = IDLE;
            end
         end
         CONVERT: begin
            {bcd_s, mag_s} = {adj_s[BCD_W-2:0], mag_r, 1'b0};
            step_s         = step_r + CNT_W'(1);
            if (step_r == LAST_STEP) begin
               state_s = COMMIT;
            end else begin
               state_s = CONVERT;
            end
         end
         COMMIT: begin
            commit_s = 1'b1;
            state_s  = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // Blank leading zeros (ones digit always shown); minus goes just left of the top nonzero digit
   always_comb begin
      logic zero_above;
      blank_s    = '0;
      sign_s     = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (zero_above && (bcd_r[i*4 +: 4] == 4'd0)) begin
            blank_s[i] = 1'b1;
         end else begin
            zero_above = 1'b0;
         end
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (neg_pend_r && blank_s[i] && !blank_s[i-1]) begin
            sign_s[i] = 1'b1;
         end else begin
            sign_s[i] = 1'b0;
         end
      end
   end
`else
   // Zero-padded digits; minus replaces the leftmost digit
   always_comb begin
      blank_s               = '0;
      sign_s                = '0;
      sign_s[NUM_DIGITS-1]  = neg_pend_r;
   end
`endif

   // Display registers, loaded only at commit so the shown value changes atomically
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_bcd_r <= '0;
         blank_r    <= '0;
         sign_r     <= '0;
      end else if (commit_s) begin
         disp_bcd_r <= bcd_r;
         blank_r    <= blank_s;
         sign_r     <= sign_s;
      end else begin
         disp_bcd_r <= disp_bcd_r;
         blank_r    <= blank_r;
         sign_r     <= sign_r;
      end
   end

   // Free-running refresh counter; the scan index advances on each wrap and wraps at the last digit
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_r <= '0;
         idx_r     <= '0;
      end else begin
         refresh_r <= refresh_r + REFRESH_BITS'(1);
         if (&refresh_r) begin
            if (idx_r == LAST_IDX) begin
               idx_r <= '0;
            end else begin
               idx_r <= idx_r + IDX_W'(1);
            end
         end else begin
            idx_r <= idx_r;
         end
      end
   end

   // Select the digit for the current scan index (index 0 = leftmost = top nibble)
   always_comb begin
      pos_s       = LAST_IDX - idx_r;
      nib_s       = 4'd0;
      dig_blank_s = 1'b0;
      dig_sign_s  = 1'b0;
      anode_s     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) == pos_s) begin
            nib_s       = disp_bcd_r[i*4 +: 4];
            dig_blank_s = blank_r[i];
            dig_sign_s  = sign_r[i];
            anode_s[i]  = 1'b0;
         end else begin
            anode_s[i]  = 1'b1;
         end
      end
      if (dig_sign_s) begin
         seg_s = 7'b1111110;
      end else if (dig_blank_s) begin
         seg_s = 7'b1111111;
      end else begin
         seg_s = seg_code(nib_s);
      end
   end

   // Registered anode and segment outputs, updated together
   always_ff @(posedge clk) begin
      if (rst) begin
         Anode   <= '1;
         LED_out <= 7'b1111111;
      end else begin
         Anode   <= anode_s;
         LED_out <= seg_s;
      end
   end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: a signed 4-digit instance and an
// unsigned 3-digit instance, both with REFRESH_BITS=2. Expected displays are
// produced by a decimal model and queued when a load is driven.
module tb_seg_display_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] num = 8'd0;
   logic       load = 1'b0;
   logic       busy;
   logic [3:0] Anode;
   logic [6:0] LED_out;
   logic [7:0] num3 = 8'd0;
   logic       load3 = 1'b0;
   logic       busy3;
   logic [2:0] Anode3;
   logic [6:0] LED_out3;

   int errors = 0;
   int checks = 0;
   logic [27:0] exp_q[$];
   logic [20:0] exp3_q[$];

   always #5 clk = ~clk;

   seg_display_driver #(.NUM_DIGITS(4), .DATA_W(8), .REFRESH_BITS(2), .SIGNED(1)) u_dut (
      .clk(clk), .rst(rst), .num(num), .load(load),
      .busy(busy), .Anode(Anode), .LED_out(LED_out)
   );

   seg_display_driver #(.NUM_DIGITS(3), .DATA_W(8), .REFRESH_BITS(2), .SIGNED(0)) u_dut3 (
      .clk(clk), .rst(rst), .num(num3), .load(load3),
      .busy(busy3), .Anode(Anode3), .LED_out(LED_out3)
   );

   // code 10 = minus, 11 = blank
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         10: return 7'b1111110;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected 4-digit signed display, leftmost digit in the top 7 bits
   function automatic logic [27:0] model4(input logic [7:0] v);
      int mag;
      bit neg;
      int code[4];
      int p;
      int first;
      neg = v[7];
      mag = neg ? (256 - int'(v)) : int'(v);
      p = 1000;
      for (int k = 0; k < 4; k++) begin
         code[k] = (mag / p) % 10;
         p = p / 10;
      end
`ifdef SEG_LEADING_ZERO_BLANK_EN
      first = 3;
      for (int k = 0; k < 3; k++) begin
         if (code[k] != 0) begin
            first = k;
            break;
         end
      end
      for (int k = 0; k < first; k++) code[k] = 11;
      if (neg) code[first-1] = 10;
`else
      first = 0;
      if (neg) code[0] = 10;
`endif
      return {seg_of(code[0]), seg_of(code[1]), seg_of(code[2]), seg_of(code[3])};
   endfunction

   task automatic grab4(output logic [27:0] obs, output bit all_seen);
      bit [3:0] seen;
      logic [3:0] pat;
      seen = 4'b0000;
      obs = '1;
      repeat (20) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            pat = 4'b1000 >> k;
            if (Anode === ~pat) begin
               obs[27-7*k -: 7] = LED_out;
               seen[k] = 1'b1;
            end
         end
      end
      all_seen = &seen;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: busy still %b after 50 cycles, required 0", name, busy);
      end
   endtask

   task automatic check_display(input string name);
      logic [27:0] obs;
      logic [27:0] expv;
      bit seen;
      grab4(obs, seen);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected display queued", name);
      end else begin
         expv = exp_q.pop_front();
         if (obs !== expv || !seen) begin
            errors++;
            $display("FAIL %s: display got %b required %b (all digits scanned=%0d)",
                     name, obs, expv, seen);
         end
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      @(negedge clk);
      num  = v;
      load = 1'b1;
      exp_q.push_back(model4(v));
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (Anode !== 4'b1111) begin errors++; $display("FAIL reset_anode: got %b required 1111", Anode); end
      checks++;
      if (LED_out !== 7'b1111111) begin errors++; $display("FAIL reset_led: got %b required 1111111", LED_out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (Anode3 !== 3'b111 || busy3 !== 1'b0) begin
         errors++; $display("FAIL reset_dut3: anode %b busy %b required 111 0", Anode3, busy3);
      end
      rst = 1'b0;
      exp_q.push_back({4{7'b0000001}});
      check_display("reset_zero");
   endtask

   task automatic test_convert;
      @(negedge clk);
      num  = 8'd123;
      load = 1'b1;
      exp_q.push_back(model4(8'd123));
      @(negedge clk);
      load = 1'b0;
      // sample i lies in the cycle i after the capture edge
      for (int i = 1; i <= 11; i++) begin
         if (i > 1) @(negedge clk);
         checks++;
         if (busy !== ((i <= 9) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL busy_timing: cycle T+%0d busy %b required %b", i, busy, (i <= 9));
         end
      end
      check_display("convert_123");
   endtask

   task automatic test_negative;
      do_load(8'h80);
      wait_idle("wait_m128");
      check_display("neg_m128");
      do_load(8'hFF);
      wait_idle("wait_m1");
      check_display("neg_m1");
   endtask

   task automatic test_random;
      logic [7:0] v;
      for (int n = 0; n < 4; n++) begin
         v = 8'($urandom_range(0, 255));
         do_load(v);
         wait_idle("wait_rand");
         check_display("random_value");
      end
   endtask

   task automatic test_ignored_load;
      do_load(8'd123);
      repeat (2) @(negedge clk);
      num  = 8'd7;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_idle("wait_ignored");
      check_display("ignored_load");
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignored_no_rerun: busy %b required 0", busy); end
   endtask

   task automatic test_reset_abort;
      @(negedge clk);
      num  = 8'd123;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
      rst = 1'b0;
      exp_q.push_back({4{7'b0000001}});
      check_display("abort_zero");
   endtask

   task automatic test_scan3;
      logic [2:0] prev_anode;
      logic [6:0] prev_led;
      logic [2:0] pat;
      logic [20:0] e3;
      int run;
      int prev_k;
      int k;
      bit ok;
      bit first_run;
      @(negedge clk);
      num3  = 8'd255;
      load3 = 1'b1;
      exp3_q.push_back({seg_of(2), seg_of(5), seg_of(5)});
      @(negedge clk);
      load3 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy3 === 1'b0) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL scan3_wait: busy3 %b required 0", busy3); end
      e3 = exp3_q.pop_front();
      repeat (2) @(negedge clk);
      prev_anode = Anode3;
      prev_led   = LED_out3;
      prev_k = -1;
      for (int j = 0; j < 3; j++) begin
         pat = 3'b100 >> j;
         if (prev_anode === ~pat) prev_k = j;
      end
      checks++;
      if (prev_k < 0) begin
         errors++; $display("FAIL scan3_pattern: anode %b required one of 011/101/110", prev_anode);
         prev_k = 0;
      end
      run = 1;
      first_run = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (Anode3 !== prev_anode) begin
            k = (prev_k + 1) % 3;
            pat = 3'b100 >> k;
            checks++;
            if (Anode3 !== ~pat) begin
               errors++; $display("FAIL scan3_order: anode %b required %b", Anode3, ~pat);
            end
            if (!first_run) begin
               checks++;
               if (run != 4) begin errors++; $display("FAIL scan3_hold: held %0d clocks required 4", run); end
            end
            first_run = 1'b0;
            run = 1;
            prev_k = k;
         end else begin
            run++;
            checks++;
            if (LED_out3 !== prev_led) begin
               errors++; $display("FAIL scan3_led_sync: led changed to %b without anode change", LED_out3);
            end
         end
         checks++;
         if (LED_out3 !== e3[20-7*prev_k -: 7]) begin
            errors++;
            $display("FAIL scan3_digit: index %0d led %b required %b", prev_k, LED_out3, e3[20-7*prev_k -: 7]);
         end
         prev_anode = Anode3;
         prev_led   = LED_out3;
      end
   endtask

   initial begin
      test_reset;
      test_convert;
      test_negative;
      test_random;
      test_ignored_load;
      test_reset_abort;
      test_scan3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
